// File: rtl/aligned_word_writer_if.sv
// aligned_word_writer_if: aligner-to-writer and writer-to-sink word handshake
interface aligned_word_writer_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  afull;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  afull, out_valid, out_data, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output afull, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aligned_word_writer.sv
// aligned_word_writer: FWFT word FIFO with afull back-pressure, word count and stream status
module aligned_word_writer #(
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  aligned_word_writer_if.slave  bus,
  output logic [ADDR_WIDTH:0]   level,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  overflow,
  output logic                  stream_done
);
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   level_n;
  logic                  full, pop, push;
  always_comb begin
    full    = level == (ADDR_WIDTH+1)'(DEPTH);
    pop     = bus.out_valid && bus.out_ready;
    push    = bus.in_valid && (!full || pop);
    level_n = clear ? '0
            : (push && !pop) ? level + (ADDR_WIDTH+1)'(1)
            : (pop && !push) ? level - (ADDR_WIDTH+1)'(1)
            : level;
  end
  // head entry is already registered, so the read side needs no extra stage
  assign bus.out_data = mem[rptr][DATA_WIDTH-1:0];
  assign bus.out_last = mem[rptr][DATA_WIDTH];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem           <= '{default: '0};
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      word_count    <= '0;
      overflow      <= 1'b0;
      stream_done   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.afull     <= 1'b0;
    end else begin
      level         <= level_n;
      bus.out_valid <= level_n != '0;
      bus.afull     <= level_n >= (ADDR_WIDTH+1)'(AFULL_THRESH);
      stream_done   <= !clear && pop && bus.out_last;
      if (clear) begin
        wptr       <= '0;
        rptr       <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= {bus.in_last, bus.in_data};
          wptr      <= wptr + ADDR_WIDTH'(1);
        end
        if (pop) begin
          rptr       <= rptr + ADDR_WIDTH'(1);
          word_count <= word_count + CNT_WIDTH'(1);
        end
        if (bus.in_valid && full && !pop) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aligned_word_writer.sv
// tb_aligned_word_writer: directed stimulus with a queue scoreboard and a negedge monitor
module tb_aligned_word_writer;
  localparam int DW = 256;
  localparam int W  = DW + 1;
  logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [3:0]  level;
  logic [31:0] word_count;
  logic        overflow, stream_done;
  logic [DW:0] sb [$];
  int          compared = 0, mismatched = 0;
  logic        exp_done = 1'b0;
  aligned_word_writer_if #(.DATA_WIDTH(DW)) bus ();
  aligned_word_writer dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus.slave),
    .level(level), .word_count(word_count), .overflow(overflow), .stream_done(stream_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) exp_done = 1'b0;
    else begin
      chk("stream_done", W'(stream_done), W'(exp_done));
      exp_done = bus.out_valid && bus.out_ready && bus.out_last && !clear;
      if (bus.out_valid && bus.out_ready && !clear) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
        end else chk("out_word", {bus.out_last, bus.out_data}, sb.pop_front());
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int v, input logic last, input bit acc);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(v);
    bus.in_last  = last;
    if (acc) sb.push_back({last, DW'(v)});
    tick(1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    sb.delete();
    tick(1);
    clear = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while ((level != 0 || sb.size() != 0) && n < 100) begin
      tick(1);
      n++;
    end
    chk("drain_empty", W'(level == 0 && sb.size() == 0), W'(1));
  endtask
  initial begin
    int sent, cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick(2);
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data", W'(bus.out_data), W'(0));
    chk("rst_out_last", W'(bus.out_last), W'(0));
    chk("rst_afull", W'(bus.afull), W'(0));
    chk("rst_level", W'(level), W'(0));
    chk("rst_word_count", W'(word_count), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
    chk("rst_stream_done", W'(stream_done), W'(0));
    reset = 1'b0;
    tick(1);
    bus.out_ready = 1'b1;
    push(1, 1'b1, 1'b1);
    chk("single_valid", W'(bus.out_valid), W'(1));
    chk("single_level", W'(level), W'(1));
    tick(1);
    chk("single_count", W'(word_count), W'(1));
    chk("single_done", W'(stream_done), W'(1));
    chk("single_empty", W'(level), W'(0));
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(i, 1'b0, 1'b1);
      if (i == 5) chk("afull_below", W'(bus.afull), W'(0));
      if (i == 6) chk("afull_at", W'(bus.afull), W'(1));
    end
    chk("fill_level", W'(level), W'(8));
    push(9, 1'b0, 1'b0);
    chk("ovf_set", W'(overflow), W'(1));
    chk("ovf_level", W'(level), W'(8));
    drain();
    chk("fill_count", W'(word_count), W'(8));
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(i, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    push(9, 1'b0, 1'b1);
    chk("full_pp_level", W'(level), W'(8));
    chk("full_pp_ovf", W'(overflow), W'(0));
    drain();
    chk("full_pp_count", W'(word_count), W'(9));
    do_clear();
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 200) begin
      bus.out_ready = (cyc % 2) == 0;
      bus.in_valid  = !bus.afull;
      bus.in_last   = 1'b0;
      if (!bus.afull) begin
        bus.in_data = DW'(1000 + sent);
        sb.push_back({1'b0, DW'(1000 + sent)});
        sent++;
      end
      tick(1);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("wrap_sent", W'(sent), W'(20));
    drain();
    chk("wrap_count", W'(word_count), W'(20));
    chk("wrap_ovf", W'(overflow), W'(0));
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(100 + i, 1'b0, 1'b1);
    push(108, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick(3);
    bus.out_ready = 1'b0;
    chk("pre_clear_level", W'(level), W'(5));
    chk("pre_clear_ovf", W'(overflow), W'(1));
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(999);
    sb.delete();
    tick(1);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_level", W'(level), W'(0));
    chk("clear_valid", W'(bus.out_valid), W'(0));
    chk("clear_ovf", W'(overflow), W'(0));
    chk("clear_count", W'(word_count), W'(0));
    tick(1);
    chk("clear_push_dropped", W'(level), W'(0));
    for (int i = 1; i <= 3; i++) push(i, 1'b0, 1'b1);
    chk("mid_valid", W'(bus.out_valid), W'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_valid", W'(bus.out_valid), W'(0));
    chk("async_rst_level", W'(level), W'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick(1);
    bus.out_ready = 1'b1;
    push('hABC, 1'b1, 1'b1);
    drain();
    chk("post_rst_count", W'(word_count), W'(1));
    tick(2);
    chk("sb_empty", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/aligned_word_writer.md
Name: aligned_word_writer

Overview:
- Downstream stage of the 256-bit aligner. Buffers each full aligned word in a small first-word-fall-through FIFO.
- Presents the buffered words to the memory/stream sink with a valid/ready handshake.
- Drives an almost-full signal that upstream control uses to deassert the aligner's wrt_en, and tracks end-of-stream and error status.

Parameters:
- DATA_WIDTH, 256, aligned word width; matches the aligner output.
- DEPTH, 8, FIFO entries; power of two.
- ADDR_WIDTH, 3, log2(DEPTH).
- AFULL_THRESH, 6, occupancy at which afull asserts; must be <= DEPTH-2.
- CNT_WIDTH, 32, width of the word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: empties the FIFO and zeroes count, overflow and done.
- in_valid  input  1  an aligned word is present this cycle; this is the aligner valid already qualified by wrt_en.
- in_data  input  DATA_WIDTH  aligned word.
- in_last  input  1  this word ends the stream; sampled only with in_valid.
- afull  output  1  occupancy >= AFULL_THRESH; upstream stops wrt_en.
- out_valid  output  1  out_data is valid.
- out_data  output  DATA_WIDTH  head word of the FIFO.
- out_last  output  1  head word carries in_last.
- out_ready  input  1  sink accepts the word this cycle.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- word_count  output  CNT_WIDTH  number of words popped since reset or clear.
- overflow  output  1  sticky: a word arrived while the FIFO was full.
- stream_done  output  1  one-cycle pulse after the last-flagged word is popped.

Behaviour:
- Reset values: all outputs are 0 (out_valid, out_data, out_last, afull, level, word_count, overflow, stream_done). Read/write pointers are 0.
- Storage: DEPTH x (DATA_WIDTH+1) array; the extra bit holds last. Pointers are ADDR_WIDTH wide and wrap modulo DEPTH. Occupancy is held in a separate counter, so full and empty are never ambiguous.
- Push: in_valid && (!full || pop). Data and last are written at wptr, and wptr increments.
- Pop: out_valid && out_ready. rptr increments.
- Simultaneous push and pop:
  - level is unchanged.
  - When full, the push is accepted because the pop frees the entry in the same cycle.
- Overflow: in_valid while full with no pop. The word is dropped, the pointers are unchanged, and overflow is set. overflow stays set until reset or clear.
- Outputs are registered and first-word-fall-through:
  - out_valid = (level != 0), registered.
  - out_data and out_last always reflect entry rptr.
  - Latency from push into an empty FIFO to out_valid is 1 cycle. There is no same-cycle bypass.
- Output stability: while out_valid && !out_ready, out_data and out_last hold steady.
- afull: registered comparison of the next level against AFULL_THRESH, updated in the same cycle as level. The gap of at least 2 below DEPTH absorbs the aligner word produced while wrt_en is still in flight.
- word_count: increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
- stream_done: asserted for exactly the one cycle after a pop whose out_last = 1.
- Multiple last-flagged words in the FIFO are allowed. Each one produces its own stream_done pulse.
- clear:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: level = 0, out_valid = 0, pointers = 0, word_count = 0, overflow = 0, stream_done = 0.
  - Any push in the clear cycle is discarded.
- Reset mid-operation: immediate asynchronous return to the reset state. Contents are lost and out_valid drops without waiting for a clock.
- No combinational path from in_* to out_*. The only combinational path from out_ready is into the pop/next-state logic.

Test Plan:
- Single word: push 0x00..01 with in_last = 1, out_ready = 1.
  -> out_valid next cycle with out_data = 0x00..01 and out_last = 1.
  -> stream_done pulses the cycle after the pop; word_count = 1.
- Fill and back-pressure: out_ready = 0, push 8 words with values 1..8.
  -> afull = 1 after the 6th push; level = 8 after the 8th.
  -> A 9th push sets overflow = 1 while level stays 8.
  -> Then out_ready = 1 drains 1..8 in order; word_count = 8.
- Full with simultaneous push/pop: at level = 8, push 9 with out_ready = 1.
  -> Word 1 is popped and 9 is accepted; level stays 8; overflow stays 0.
  -> The drain order is 2..9.
- Wrap-around: stream 20 words with out_ready toggling 1,0,1,0.
  -> Output sequence equals input sequence; pointers wrap twice; no loss; word_count = 20.
- Clear and reset: with level = 5 and overflow = 1, assert clear together with in_valid.
  -> Next cycle level = 0, out_valid = 0, overflow = 0, word_count = 0.
  -> Assert reset asynchronously mid-stream: out_valid goes to 0 before the next clock edge.
